// File: rtl/pflink_rx_deframer.sv
// Receive-side deframer for the optical link word stream.
// Recovers length-prefixed frames, drops PAD fill, forwards payload with the
// frame tag, verifies the trailing additive checksum and keeps frame counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// HUNT    | waiting for a valid SOF; all other words are ignored
// PAYLOAD | forwarding DATA words, remaining-word down-counter running
// CHECK   | next DATA word is the checksum for the frame just forwarded
module pflink_rx_deframer #(
  parameter int MAX_LEN   = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_link,
  input  logic                 reset,
  input  logic [31:0]          rx_d,
  input  logic [3:0]           rx_k,
  input  logic                 rx_v,
  input  logic                 counter_reset,
  output logic                 out_valid,
  output logic [31:0]          out_data,
  output logic                 out_first,
  output logic [15:0]          out_tag,
  output logic                 frame_done,
  output logic                 frame_ok,
  output logic [2:0]           frame_err,
  output logic [CNT_WIDTH-1:0] frames_good,
  output logic [CNT_WIDTH-1:0] frames_bad
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  localparam logic [7:0]           MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  state_t      state;
  logic [7:0]  rem_cnt;
  logic [31:0] sum_q;
  logic        first_q;
  // An invalid SOF that interrupts a frame owes a second done pulse, which
  // has to wait for the slot after the old frame's framing abort.
  logic        pend_bad_sof;

  logic       is_sof;
  logic       is_data;
  logic       is_pad;
  logic [7:0] sof_len;
  logic       sof_len_ok;

  // Word classification; everything outside SOF/DATA/PAD acts as an abort cause.
  always_comb begin
    is_sof     = rx_v && (rx_k == 4'b0001) && (rx_d[7:0] == 8'hBC);
    is_data    = rx_v && (rx_k == 4'h0);
    is_pad     = rx_v && (rx_k == 4'hF) && (rx_d == 32'h1C1C_1C1C);
    sof_len    = rx_d[15:8];
    sof_len_ok = (sof_len != 8'd0) && (sof_len <= MAX_LEN_B);
  end

  // Frame FSM with registered payload and completion outputs.
  always_ff @(posedge clk_link) begin
    if (reset) begin
      state        <= HUNT;
      rem_cnt      <= 8'd0;
      sum_q        <= 32'd0;
      first_q      <= 1'b0;
      pend_bad_sof <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= 32'd0;
      out_first    <= 1'b0;
      out_tag      <= 16'd0;
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
      frame_err    <= 3'b000;
    end else begin
      out_valid    <= 1'b0;
      out_first    <= 1'b0;
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
      frame_err    <= 3'b000;
      pend_bad_sof <= 1'b0;

      if (pend_bad_sof) begin
        frame_done <= 1'b1;
        frame_err  <= 3'b100;
      end

      if (!is_pad) begin
        case (state)
          HUNT: begin
            if (is_sof) begin
              if (sof_len_ok) begin
                state   <= PAYLOAD;
                rem_cnt <= sof_len;
                sum_q   <= 32'd0;
                first_q <= 1'b1;
                out_tag <= rx_d[31:16];
              end else if (pend_bad_sof) begin
                // Done slot already taken by the deferred abort; defer again.
                pend_bad_sof <= 1'b1;
              end else begin
                frame_done <= 1'b1;
                frame_err  <= 3'b100;
              end
            end
          end

          PAYLOAD, CHECK: begin
            if (is_data) begin
              if (state == PAYLOAD) begin
                out_valid <= 1'b1;
                out_data  <= rx_d;
                out_first <= first_q;
                first_q   <= 1'b0;
                sum_q     <= sum_q + rx_d;
                rem_cnt   <= rem_cnt - 8'd1;
                if (rem_cnt == 8'd1) begin
                  state <= CHECK;
                end
              end else begin
                frame_done <= 1'b1;
                frame_ok   <= (rx_d == sum_q);
                frame_err  <= (rx_d == sum_q) ? 3'b000 : 3'b001;
                state      <= HUNT;
              end
            end else if (is_sof) begin
              // Old frame ends with a framing abort; the new SOF is taken as in HUNT.
              frame_done <= 1'b1;
              frame_err  <= 3'b100;
              if (sof_len_ok) begin
                state   <= PAYLOAD;
                rem_cnt <= sof_len;
                sum_q   <= 32'd0;
                first_q <= 1'b1;
                out_tag <= rx_d[31:16];
              end else begin
                pend_bad_sof <= 1'b1;
                state        <= HUNT;
              end
            end else begin
              frame_done <= 1'b1;
              frame_err  <= 3'b010;
              state      <= HUNT;
            end
          end

          default: state <= HUNT;
        endcase
      end
    end
  end

  // Saturating good/bad frame counters; counter_reset wins over increment.
  always_ff @(posedge clk_link) begin
    if (reset || counter_reset) begin
      frames_good <= '0;
      frames_bad  <= '0;
    end else if (frame_done) begin
      if (frame_ok) begin
        if (frames_good != CNT_MAX) frames_good <= frames_good + 1'b1;
      end else begin
        if (frames_bad != CNT_MAX) frames_bad <= frames_bad + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pflink_rx_deframer.sv
// Directed bench for pflink_rx_deframer. A second instance with 2-bit
// counters sees the same stimulus so counter saturation is reached quickly.
module tb_pflink_rx_deframer;

  logic        clk_link = 1'b0;
  logic        reset;
  logic [31:0] rx_d;
  logic [3:0]  rx_k;
  logic        rx_v;
  logic        counter_reset;

  logic        out_valid, out_first, frame_done, frame_ok;
  logic [31:0] out_data;
  logic [15:0] out_tag;
  logic [2:0]  frame_err;
  logic [15:0] frames_good, frames_bad;

  logic        s_valid, s_first, s_done, s_ok;
  logic [31:0] s_data;
  logic [15:0] s_tag;
  logic [2:0]  s_err;
  logic [1:0]  s_good, s_bad;

  int checks = 0;
  int errors = 0;
  int exp_good = 0;
  int exp_bad = 0;
  logic [31:0] last_dat = 32'd0;

  pflink_rx_deframer #(.MAX_LEN(64), .CNT_WIDTH(16)) dut (
    .clk_link(clk_link), .reset(reset), .rx_d(rx_d), .rx_k(rx_k), .rx_v(rx_v),
    .counter_reset(counter_reset), .out_valid(out_valid), .out_data(out_data),
    .out_first(out_first), .out_tag(out_tag), .frame_done(frame_done),
    .frame_ok(frame_ok), .frame_err(frame_err), .frames_good(frames_good),
    .frames_bad(frames_bad)
  );

  pflink_rx_deframer #(.MAX_LEN(64), .CNT_WIDTH(2)) dut_sat (
    .clk_link(clk_link), .reset(reset), .rx_d(rx_d), .rx_k(rx_k), .rx_v(rx_v),
    .counter_reset(counter_reset), .out_valid(s_valid), .out_data(s_data),
    .out_first(s_first), .out_tag(s_tag), .frame_done(s_done),
    .frame_ok(s_ok), .frame_err(s_err), .frames_good(s_good),
    .frames_bad(s_bad)
  );

  always #5 clk_link = ~clk_link;

  task automatic drive(input logic v, input logic [3:0] k, input logic [31:0] d);
    rx_v = v; rx_k = k; rx_d = d;
    @(posedge clk_link);
    #1;
  endtask

  task automatic sof(input logic [7:0] len, input logic [15:0] tag);
    drive(1'b1, 4'b0001, {tag, len, 8'hBC});
  endtask

  task automatic data(input logic [31:0] w);
    drive(1'b1, 4'h0, w);
  endtask

  task automatic pad();
    drive(1'b1, 4'hF, 32'h1C1C_1C1C);
  endtask

  task automatic idle();
    drive(1'b1, 4'hF, 32'hF7F7_F7F7);
  endtask

  task automatic novalid();
    drive(1'b0, 4'h0, 32'h1234_5678);
  endtask

  // Outputs expected right after the word just driven has been clocked in.
  task automatic expect_out(input string nm, input logic vld, input logic [31:0] dat,
                            input logic first, input logic done, input logic ok,
                            input logic [2:0] err);
    if (vld) last_dat = dat;
    checks++;
    assert (out_valid === vld) else begin
      errors++; $error("FAIL %s out_valid got %0b exp %0b", nm, out_valid, vld);
    end
    checks++;
    assert (out_data === last_dat) else begin
      errors++; $error("FAIL %s out_data got %h exp %h", nm, out_data, last_dat);
    end
    checks++;
    assert (out_first === (vld & first)) else begin
      errors++; $error("FAIL %s out_first got %0b exp %0b", nm, out_first, vld & first);
    end
    checks++;
    assert (frame_done === done) else begin
      errors++; $error("FAIL %s frame_done got %0b exp %0b", nm, frame_done, done);
    end
    checks++;
    assert (frame_ok === ok) else begin
      errors++; $error("FAIL %s frame_ok got %0b exp %0b", nm, frame_ok, ok);
    end
    checks++;
    assert (frame_err === err) else begin
      errors++; $error("FAIL %s frame_err got %b exp %b", nm, frame_err, err);
    end
    checks++;
    assert (s_done === done && s_err === err && s_valid === vld) else begin
      errors++; $error("FAIL %s sat_inst done/err/valid got %0b/%b/%0b exp %0b/%b/%0b",
                       nm, s_done, s_err, s_valid, done, err, vld);
    end
  endtask

  task automatic expect_tag(input string nm, input logic [15:0] tag);
    checks++;
    assert (out_tag === tag) else begin
      errors++; $error("FAIL %s out_tag got %h exp %h", nm, out_tag, tag);
    end
  endtask

  task automatic expect_cnt(input string nm);
    logic [1:0] sg, sb;
    sg = (exp_good > 3) ? 2'd3 : 2'(exp_good);
    sb = (exp_bad > 3) ? 2'd3 : 2'(exp_bad);
    checks++;
    assert (frames_good === 16'(exp_good)) else begin
      errors++; $error("FAIL %s frames_good got %0d exp %0d", nm, frames_good, exp_good);
    end
    checks++;
    assert (frames_bad === 16'(exp_bad)) else begin
      errors++; $error("FAIL %s frames_bad got %0d exp %0d", nm, frames_bad, exp_bad);
    end
    checks++;
    assert (s_good === sg && s_bad === sb) else begin
      errors++; $error("FAIL %s sat_counters got %0d/%0d exp %0d/%0d", nm, s_good, s_bad, sg, sb);
    end
  endtask

  initial begin
    reset = 1'b1; rx_v = 1'b0; rx_k = 4'h0; rx_d = 32'd0; counter_reset = 1'b0;
    repeat (2) @(posedge clk_link);
    #1;
    expect_out("reset", 0, 32'd0, 0, 0, 0, 3'b000);
    expect_tag("reset_tag", 16'h0000);
    expect_cnt("reset_cnt");
    reset = 1'b0;

    // Good frame: 1+2+3 = 6
    sof(8'd3, 16'hBEEF);  expect_out("s1_sof", 0, 0, 0, 0, 0, 3'b000);
    data(32'd1);          expect_out("s1_d0", 1, 32'd1, 1, 0, 0, 3'b000);
    expect_tag("s1_tag", 16'hBEEF);
    data(32'd2);          expect_out("s1_d1", 1, 32'd2, 0, 0, 0, 3'b000);
    data(32'd3);          expect_out("s1_d2", 1, 32'd3, 0, 0, 0, 3'b000);
    data(32'd6);          expect_out("s1_ck", 0, 0, 0, 1, 1, 3'b000);
    exp_good++;
    idle();               expect_out("s1_idle", 0, 0, 0, 0, 0, 3'b000);
    expect_cnt("s1_cnt");

    // Bad checksum
    sof(8'd3, 16'hBEEF);  expect_out("s2_sof", 0, 0, 0, 0, 0, 3'b000);
    data(32'd1);          expect_out("s2_d0", 1, 32'd1, 1, 0, 0, 3'b000);
    data(32'd2);          expect_out("s2_d1", 1, 32'd2, 0, 0, 0, 3'b000);
    data(32'd3);          expect_out("s2_d2", 1, 32'd3, 0, 0, 0, 3'b000);
    data(32'd7);          expect_out("s2_ck", 0, 0, 0, 1, 0, 3'b001);
    exp_bad++;
    idle();               expect_cnt("s2_cnt");

    // PAD interleaved everywhere
    sof(8'd3, 16'hBEEF);  expect_out("s3_sof", 0, 0, 0, 0, 0, 3'b000);
    pad();                expect_out("s3_p0", 0, 0, 0, 0, 0, 3'b000);
    data(32'd1);          expect_out("s3_d0", 1, 32'd1, 1, 0, 0, 3'b000);
    pad();                expect_out("s3_p1", 0, 0, 0, 0, 0, 3'b000);
    data(32'd2);          expect_out("s3_d1", 1, 32'd2, 0, 0, 0, 3'b000);
    pad();                expect_out("s3_p2", 0, 0, 0, 0, 0, 3'b000);
    data(32'd3);          expect_out("s3_d2", 1, 32'd3, 0, 0, 0, 3'b000);
    pad();                expect_out("s3_p3", 0, 0, 0, 0, 0, 3'b000);
    data(32'd6);          expect_out("s3_ck", 0, 0, 0, 1, 1, 3'b000);
    exp_good++;
    idle();               expect_cnt("s3_cnt");

    // Truncation by rx_v=0, then a LEN=1 frame is accepted
    sof(8'd3, 16'h1234);  expect_out("s4_sof", 0, 0, 0, 0, 0, 3'b000);
    data(32'd5);          expect_out("s4_d0", 1, 32'd5, 1, 0, 0, 3'b000);
    data(32'd6);          expect_out("s4_d1", 1, 32'd6, 0, 0, 0, 3'b000);
    novalid();            expect_out("s4_trunc", 0, 0, 0, 1, 0, 3'b010);
    exp_bad++;
    data(32'd99);         expect_out("s4_hunt_data", 0, 0, 0, 0, 0, 3'b000);
    sof(8'd1, 16'h0042);  expect_out("s4b_sof", 0, 0, 0, 0, 0, 3'b000);
    data(32'd9);          expect_out("s4b_d0", 1, 32'd9, 1, 0, 0, 3'b000);
    expect_tag("s4b_tag", 16'h0042);
    data(32'd9);          expect_out("s4b_ck", 0, 0, 0, 1, 1, 3'b000);
    exp_good++;
    idle();               expect_cnt("s4_cnt");

    // Framing abort by a valid SOF, second frame completes with new tag
    sof(8'd4, 16'hAAAA);  expect_out("s5_sof", 0, 0, 0, 0, 0, 3'b000);
    data(32'd10);         expect_out("s5_d0", 1, 32'd10, 1, 0, 0, 3'b000);
    sof(8'd2, 16'h5555);  expect_out("s5_sof2", 0, 0, 0, 1, 0, 3'b100);
    exp_bad++;
    data(32'd1);          expect_out("s5b_d0", 1, 32'd1, 1, 0, 0, 3'b000);
    expect_tag("s5b_tag", 16'h5555);
    data(32'd2);          expect_out("s5b_d1", 1, 32'd2, 0, 0, 0, 3'b000);
    data(32'd3);          expect_out("s5b_ck", 0, 0, 0, 1, 1, 3'b000);
    exp_good++;
    idle();               expect_cnt("s5_cnt");

    // Invalid LEN values
    sof(8'd0, 16'h0001);  expect_out("s6_len0", 0, 0, 0, 1, 0, 3'b100);
    exp_bad++;
    idle();               expect_out("s6_idle", 0, 0, 0, 0, 0, 3'b000);
    sof(8'd65, 16'h0002); expect_out("s6_len65", 0, 0, 0, 1, 0, 3'b100);
    exp_bad++;
    data(32'd1);          expect_out("s6_hunt", 0, 0, 0, 0, 0, 3'b000);

    // Invalid SOF interrupting a frame: two done pulses back to back
    sof(8'd2, 16'h0003);  expect_out("s7_sof", 0, 0, 0, 0, 0, 3'b000);
    data(32'd4);          expect_out("s7_d0", 1, 32'd4, 1, 0, 0, 3'b000);
    sof(8'd0, 16'h0004);  expect_out("s7_abort", 0, 0, 0, 1, 0, 3'b100);
    idle();               expect_out("s7_second", 0, 0, 0, 1, 0, 3'b100);
    exp_bad += 2;
    idle();               expect_out("s7_quiet", 0, 0, 0, 0, 0, 3'b000);
    expect_cnt("s7_cnt");

    // Checksum wraps mod 2^32: FFFFFFFF + 2 = 1
    sof(8'd2, 16'hC0DE);  expect_out("s8_sof", 0, 0, 0, 0, 0, 3'b000);
    data(32'hFFFF_FFFF);  expect_out("s8_d0", 1, 32'hFFFF_FFFF, 1, 0, 0, 3'b000);
    data(32'd2);          expect_out("s8_d1", 1, 32'd2, 0, 0, 0, 3'b000);
    data(32'd1);          expect_out("s8_ck", 0, 0, 0, 1, 1, 3'b000);
    exp_good++;
    idle();               expect_cnt("s8_cnt");

    // counter_reset coincident with frame_done
    sof(8'd1, 16'h0BAD);  expect_out("s9_sof", 0, 0, 0, 0, 0, 3'b000);
    data(32'd4);          expect_out("s9_d0", 1, 32'd4, 1, 0, 0, 3'b000);
    data(32'd4);          expect_out("s9_ck", 0, 0, 0, 1, 1, 3'b000);
    counter_reset = 1'b1;
    idle();
    counter_reset = 1'b0;
    exp_good = 0; exp_bad = 0;
    expect_cnt("s9_cnt");

    // Reset mid-frame: no done, frame discarded
    sof(8'd2, 16'h7777);  expect_out("s10_sof", 0, 0, 0, 0, 0, 3'b000);
    data(32'd8);          expect_out("s10_d0", 1, 32'd8, 1, 0, 0, 3'b000);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    last_dat = 32'd0;
    expect_out("s10_rst", 0, 0, 0, 0, 0, 3'b000);
    data(32'd8);          expect_out("s10_hunt", 0, 0, 0, 0, 0, 3'b000);
    data(32'd16);         expect_out("s10_hunt2", 0, 0, 0, 0, 0, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
